// File: rtl/kugelblitz_pkg.sv
// Shared types and constants for the kugelblitz byte-patch engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package kugelblitz_pkg;

  localparam int KG_DATA_WIDTH   = 512;
  localparam int KG_KEEP_WIDTH   = KG_DATA_WIDTH / 8;
  localparam int KG_OFFSET_WIDTH = 11;
  // Beat offset carries one extra bit so it can run past the last patchable byte
  localparam int KG_BOFF_WIDTH   = KG_OFFSET_WIDTH + 1;

  // Beat offset saturates here instead of wrapping back onto patchable offsets
  localparam logic [KG_BOFF_WIDTH-1:0] KG_OFF_SAT = '1;

  typedef struct packed {
    logic                       enable;
    logic [KG_OFFSET_WIDTH-1:0] offset;
    logic [7:0]                 value;
    logic [7:0]                 mask;
  } kg_rule_t;

  localparam int KG_RULE_WIDTH = $bits(kg_rule_t);

  typedef enum logic {
    KG_IDLE  = 1'b0,
    KG_FRAME = 1'b1
  } kg_state_e;

endpackage

// File: rtl/kugelblitz_patch_rule.sv
// One patch rule evaluated against one beat: which byte lanes it hits.
// Latency: purely combinational.
// Backpressure: none; the top level qualifies results with the handshake.
module kugelblitz_patch_rule
  import kugelblitz_pkg::*;
#(
  parameter int KEEP_WIDTH = KG_KEEP_WIDTH
) (
  input  kg_rule_t                 rule_i,
  input  logic [KG_BOFF_WIDTH-1:0] beat_off_i,
  input  logic [KEEP_WIDTH-1:0]    keep_i,
  output logic [KEEP_WIDTH-1:0]    match_o,
  output logic [7:0]               value_o,
  output logic [7:0]               mask_o
);

  localparam int IDX_W = $clog2(KEEP_WIDTH);
  localparam logic [KG_BOFF_WIDTH-1:0] KEEP_W_L = KG_BOFF_WIDTH'(KEEP_WIDTH);

  logic [KG_BOFF_WIDTH-1:0] rule_off;
  logic [KG_BOFF_WIDTH-1:0] delta;
  logic                     in_beat;

  // The rule hits at most one lane: the one at (rule offset - beat offset)
  always_comb begin
    rule_off = {1'b0, rule_i.offset};
    delta    = rule_off - beat_off_i;
    in_beat  = rule_i.enable && (rule_off >= beat_off_i) && (delta < KEEP_W_L);
    match_o  = in_beat ? ((KEEP_WIDTH'(1) << delta[IDX_W-1:0]) & keep_i) : '0;
  end

  assign value_o = rule_i.value;
  assign mask_o  = rule_i.mask;

endmodule

// File: rtl/kugelblitz_patch_engine.sv
// AXI-stream byte-patch engine: RULE_COUNT masked byte rewrites at any frame offset.
// Latency: 1 cycle, full throughput through a single output register.
// Backpressure: s_axis_tready = !m_axis_tvalid || m_axis_tready; output holds while stalled.
// Optional: define KUGELBLITZ_PATCH_STATS_EN to add frame/patch statistics counters.
module kugelblitz_patch_engine
  import kugelblitz_pkg::*;
#(
  parameter int DATA_WIDTH     = KG_DATA_WIDTH,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = 1,
  parameter int RULE_COUNT     = 4,
  parameter int OFFSET_WIDTH   = KG_OFFSET_WIDTH,
  parameter int RULE_IDX_WIDTH = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [USER_WIDTH-1:0]     m_axis_tuser,
  input  logic                      cfg_wr_en,
  input  logic [RULE_IDX_WIDTH-1:0] cfg_wr_index,
  input  logic [OFFSET_WIDTH-1:0]   cfg_wr_offset,
  input  logic [7:0]                cfg_wr_value,
  input  logic [7:0]                cfg_wr_mask,
  input  logic                      cfg_wr_enable,
  output logic                      frame_active
`ifdef KUGELBLITZ_PATCH_STATS_EN
  ,
  output logic [31:0]               stat_frames,
  output logic [31:0]               stat_patched_frames,
  output logic [31:0]               stat_patched_bytes
`endif
);

  localparam logic [RULE_IDX_WIDTH:0] RULE_CNT_L = (RULE_IDX_WIDTH + 1)'(RULE_COUNT);
  localparam logic [KG_BOFF_WIDTH:0]  KEEP_ADD_L = (KG_BOFF_WIDTH + 1)'(KEEP_WIDTH);

  kg_state_e                state_q;
  logic                     frame_active_q;
  logic [KG_BOFF_WIDTH-1:0] beat_off_q;
  kg_rule_t                 shadow_q  [RULE_COUNT];
  kg_rule_t                 active_q  [RULE_COUNT];
  kg_rule_t                 shadow_d  [RULE_COUNT];
  kg_rule_t                 eff_rules [RULE_COUNT];

  logic                     m_vld_q;
  logic [DATA_WIDTH-1:0]    m_dat_q;
  logic [KEEP_WIDTH-1:0]    m_keep_q;
  logic                     m_last_q;
  logic [USER_WIDTH-1:0]    m_user_q;

  logic                     s_acc;
  logic [KG_BOFF_WIDTH-1:0] cur_off;
  logic [KG_BOFF_WIDTH:0]   off_sum;
  logic [KG_BOFF_WIDTH-1:0] next_off;
  logic [DATA_WIDTH-1:0]    patched_dat;
  logic [7:0]               byte_out;

  logic [KEEP_WIDTH-1:0]    rule_match [RULE_COUNT];
  logic [7:0]               rule_val   [RULE_COUNT];
  logic [7:0]               rule_msk   [RULE_COUNT];

  assign s_axis_tready = !m_vld_q || m_axis_tready;
  assign s_acc         = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign frame_active  = frame_active_q;

  // Shadow set with this cycle's config write folded in, so a write on the committing beat is included
  always_comb begin
    for (int r = 0; r < RULE_COUNT; r++) begin
      shadow_d[r] = shadow_q[r];
    end
    if (cfg_wr_en && ({1'b0, cfg_wr_index} < RULE_CNT_L)) begin
      shadow_d[cfg_wr_index] = '{enable: cfg_wr_enable, offset: cfg_wr_offset,
                                 value: cfg_wr_value, mask: cfg_wr_mask};
    end
  end

  // A beat in IDLE starts a frame: it sees freshly committed rules and offset 0
  always_comb begin
    for (int r = 0; r < RULE_COUNT; r++) begin
      eff_rules[r] = (state_q == KG_IDLE) ? shadow_d[r] : active_q[r];
    end
    cur_off  = (state_q == KG_IDLE) ? '0 : beat_off_q;
    off_sum  = {1'b0, cur_off} + KEEP_ADD_L;
    next_off = off_sum[KG_BOFF_WIDTH] ? KG_OFF_SAT : off_sum[KG_BOFF_WIDTH-1:0];
  end

  for (genvar r = 0; r < RULE_COUNT; r++) begin : g_rule
    kugelblitz_patch_rule #(
      .KEEP_WIDTH (KEEP_WIDTH)
    ) u_rule (
      .rule_i     (eff_rules[r]),
      .beat_off_i (cur_off),
      .keep_i     (s_axis_tkeep),
      .match_o    (rule_match[r]),
      .value_o    (rule_val[r]),
      .mask_o     (rule_msk[r])
    );
  end

  // Per-lane priority mux: later (higher-index) rules override earlier ones
  always_comb begin
    patched_dat = '0;
    byte_out    = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      byte_out = s_axis_tdata[8*k +: 8];
      for (int r = 0; r < RULE_COUNT; r++) begin
        if (rule_match[r][k]) begin
          byte_out = (s_axis_tdata[8*k +: 8] & ~rule_msk[r]) | (rule_val[r] & rule_msk[r]);
        end
      end
      patched_dat[8*k +: 8] = s_axis_tkeep[k] ? byte_out : 8'h00;
    end
  end

  // Output register: load on accept, drop valid once drained, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q  <= 1'b0;
      m_dat_q  <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
      m_user_q <= '0;
    end else if (s_axis_tready) begin
      m_vld_q <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        m_dat_q  <= patched_dat;
        m_keep_q <= s_axis_tkeep;
        m_last_q <= s_axis_tlast;
        m_user_q <= s_axis_tuser;
      end
    end
  end

  // Frame FSM, beat offset and rule commit at frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= KG_IDLE;
      frame_active_q <= 1'b0;
      beat_off_q     <= '0;
      for (int r = 0; r < RULE_COUNT; r++) begin
        shadow_q[r] <= '0;
        active_q[r] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (s_acc) begin
        if (state_q == KG_IDLE) begin
          active_q <= shadow_d;
        end
        if (s_axis_tlast) begin
          state_q        <= KG_IDLE;
          frame_active_q <= 1'b0;
          beat_off_q     <= '0;
        end else begin
          state_q        <= KG_FRAME;
          frame_active_q <= 1'b1;
          beat_off_q     <= next_off;
        end
      end
    end
  end

`ifdef KUGELBLITZ_PATCH_STATS_EN
  localparam int CNT_W = $clog2(KEEP_WIDTH) + 1;

  logic [KEEP_WIDTH-1:0] patch_hit;
  logic [CNT_W-1:0]      patch_cnt;
  logic                  frame_seen;
  logic                  frame_patched_q;
  logic [31:0]           stat_frames_q;
  logic [31:0]           stat_pframes_q;
  logic [31:0]           stat_pbytes_q;

  assign stat_frames         = stat_frames_q;
  assign stat_patched_frames = stat_pframes_q;
  assign stat_patched_bytes  = stat_pbytes_q;

  // Lanes actually rewritten this beat (match already excludes tkeep=0 lanes)
  always_comb begin
    patch_hit = '0;
    for (int r = 0; r < RULE_COUNT; r++) begin
      patch_hit = patch_hit | rule_match[r];
    end
    patch_cnt = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      patch_cnt = patch_cnt + CNT_W'(patch_hit[k]);
    end
    frame_seen = (|patch_hit) || ((state_q == KG_FRAME) && frame_patched_q);
  end

  // Statistics counters, all wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_patched_q <= 1'b0;
      stat_frames_q   <= '0;
      stat_pframes_q  <= '0;
      stat_pbytes_q   <= '0;
    end else if (s_acc) begin
      stat_pbytes_q <= stat_pbytes_q + 32'(patch_cnt);
      if (s_axis_tlast) begin
        frame_patched_q <= 1'b0;
        stat_frames_q   <= stat_frames_q + 32'd1;
        if (frame_seen) begin
          stat_pframes_q <= stat_pframes_q + 32'd1;
        end
      end else begin
        frame_patched_q <= frame_seen;
      end
    end
  end
`endif

endmodule

// File: tb/tb_kugelblitz_patch_engine.sv
// Self-checking bench for kugelblitz_patch_engine: directed cases plus randomized traffic
// against a frame-level reference model (rule tables, beat index, byte offsets).
// Inputs driven on negedge; outputs sampled 1 time unit later.
module tb_kugelblitz_patch_engine;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  typedef struct packed {
    logic        en;
    logic [10:0] off;
    logic [7:0]  val;
    logic [7:0]  msk;
  } mrule_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [10:0] off;
    logic [7:0]  val;
    logic [7:0]  msk;
    logic        en;
  } mcfg_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [0:0]   s_axis_tuser;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [0:0]   m_axis_tuser;
  logic         cfg_wr_en;
  logic [1:0]   cfg_wr_index;
  logic [10:0]  cfg_wr_offset;
  logic [7:0]   cfg_wr_value;
  logic [7:0]   cfg_wr_mask;
  logic         cfg_wr_enable;
  logic         frame_active;
`ifdef KUGELBLITZ_PATCH_STATS_EN
  logic [31:0]  stat_frames;
  logic [31:0]  stat_patched_frames;
  logic [31:0]  stat_patched_bytes;
`endif

  kugelblitz_patch_engine dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_index  (cfg_wr_index),
    .cfg_wr_offset (cfg_wr_offset),
    .cfg_wr_value  (cfg_wr_value),
    .cfg_wr_mask   (cfg_wr_mask),
    .cfg_wr_enable (cfg_wr_enable),
    .frame_active  (frame_active)
`ifdef KUGELBLITZ_PATCH_STATS_EN
    ,
    .stat_frames         (stat_frames),
    .stat_patched_frames (stat_patched_frames),
    .stat_patched_bytes  (stat_patched_bytes)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  mrule_t        sh [4];
  mrule_t        ac [4];
  beat_t         exp_q [$];
  logic [511:0]  out_q [$];
  bit            m_idle = 1'b1;
  int            beat_n = 0;
  bit            prev_acc = 1'b0;
  bit            stalled_prev = 1'b0;
  beat_t         held;
  int            in_total = 0;
  int            out_total = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [7:0] ob(input int i, input int b);
    logic [511:0] w;
    if (i >= out_q.size()) return 8'hxx;
    w = out_q[i];
    return w[8*b +: 8];
  endfunction

  function automatic beat_t mk_beat(input logic [7:0] fill, input logic [63:0] keep, input bit last);
    beat_t b;
    b.d = {64{fill}};
    b.k = keep;
    b.l = last;
    b.u = last;
    return b;
  endfunction

  function automatic mcfg_t mk_cfg(input int idx, input int off, input logic [7:0] val,
                                   input logic [7:0] msk, input bit en);
    mcfg_t c;
    c.idx = 2'(idx);
    c.off = 11'(off);
    c.val = val;
    c.msk = msk;
    c.en  = en;
    return c;
  endfunction

  // Frame-level model: rules snapshot at frame start, byte offset = beat index*64 + lane
  task automatic model_accept(input beat_t b);
    beat_t      e;
    int         base;
    int         w;
    logic [7:0] x;
    if (m_idle) begin
      ac     = sh;
      beat_n = 0;
    end
    base = beat_n * 64;
    if (base > 4095) base = 4095;
    e = b;
    for (int k = 0; k < 64; k++) begin
      x = b.d[8*k +: 8];
      w = -1;
      for (int r = 0; r < 4; r++) begin
        if (ac[r].en && (int'(ac[r].off) == base + k)) w = r;
      end
      if (!b.k[k]) x = 8'h00;
      else if (w >= 0) x = (x & ~ac[w].msk) | (ac[w].val & ac[w].msk);
      e.d[8*k +: 8] = x;
    end
    exp_q.push_back(e);
    in_total++;
    if (b.l) m_idle = 1'b1;
    else begin
      m_idle = 1'b0;
      beat_n++;
    end
  endtask

  // One clock of stimulus plus output monitoring; called right after a negedge
  task automatic step(input bit bv, input beat_t b, input bit cw, input mcfg_t c,
                      input bit rdy, output bit acc);
    beat_t e;
    s_axis_tvalid = bv;
    s_axis_tdata  = b.d;
    s_axis_tkeep  = b.k;
    s_axis_tlast  = b.l;
    s_axis_tuser  = b.u;
    cfg_wr_en     = cw;
    cfg_wr_index  = c.idx;
    cfg_wr_offset = c.off;
    cfg_wr_value  = c.val;
    cfg_wr_mask   = c.msk;
    cfg_wr_enable = c.en;
    m_axis_tready = rdy;
    #1;
    if (prev_acc) chk("latency_vld", m_axis_tvalid, 1'b1);
    if (stalled_prev) begin
      chk("stall_vld", m_axis_tvalid, 1'b1);
      chk("stall_dat", m_axis_tdata, held.d);
      chk("stall_ctl", {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, {held.k, held.l, held.u});
    end
    chk("s_tready", s_axis_tready, !m_axis_tvalid || rdy);
    chk("frame_active", frame_active, !m_idle);
    if (m_axis_tvalid && rdy) begin
      chk("beat_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_dat", m_axis_tdata, e.d);
        chk("out_ctl", {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, {e.k, e.l, e.u});
      end
      out_q.push_back(m_axis_tdata);
      out_total++;
    end
    stalled_prev = m_axis_tvalid && !rdy;
    held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    if (cw) sh[c.idx] = '{en: c.en, off: c.off, val: c.val, msk: c.msk};
    acc = bv && s_axis_tready;
    if (acc) model_accept(b);
    prev_acc = acc;
    @(negedge clk);
  endtask

  task automatic send_beat(input beat_t b, input bit cw, input mcfg_t c, input bit rnd);
    bit acc;
    bit w;
    int n;
    w = cw;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      step(1'b1, b, w, c, rnd ? ($urandom_range(0, 9) < 3) : 1'b1, acc);
      w = 1'b0;
      n++;
    end
    if (!acc) chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic cfg(input int idx, input int off, input logic [7:0] val, input logic [7:0] msk, input bit en);
    bit acc;
    step(1'b0, '0, 1'b1, mk_cfg(idx, off, val, msk, en), 1'b1, acc);
  endtask

  task automatic clear_rules();
    for (int r = 0; r < 4; r++) cfg(r, 0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((exp_q.size() > 0 || m_axis_tvalid) && n < 100) begin
      step(1'b0, '0, 1'b0, '0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 4; r++) begin
      sh[r] = '0;
      ac[r] = '0;
    end
    exp_q.delete();
    m_idle = 1'b1;
    beat_n = 0;
    prev_acc = 1'b0;
    stalled_prev = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    beat_t b;
    int    base;
    int    nb;
    bit    acc;
    logic [63:0] kp;

    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    m_axis_tready = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_index = '0; cfg_wr_offset = '0; cfg_wr_value = '0; cfg_wr_mask = '0; cfg_wr_enable = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_ctl", {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, '0);
    chk("rst_frame_active", frame_active, 1'b0);
    rst = 1'b0;

    // EtherType high byte rewrite in a single 64-byte frame
    out_q.delete();
    cfg(0, 12, 8'h86, 8'hFF, 1'b1);
    send_beat(mk_beat(8'hAA, '1, 1'b1), 1'b0, '0, 1'b0);
    drain();
    chk("t1_byte12", ob(0, 12), 8'h86);
    chk("t1_byte11", ob(0, 11), 8'hAA);
    chk("t1_byte13", ob(0, 13), 8'hAA);

    // Offset 70 lands on lane 6 of the second beat; partial mask
    clear_rules();
    cfg(1, 70, 8'h03, 8'h0F, 1'b1);
    out_q.delete();
    for (int i = 0; i < 3; i++) send_beat(mk_beat(8'h5C, '1, i == 2), 1'b0, '0, 1'b0);
    drain();
    chk("t2_beat1_b6", ob(1, 6), 8'h53);
    chk("t2_beat0_b6", ob(0, 6), 8'h5C);
    chk("t2_beat2_b6", ob(2, 6), 8'h5C);

    // Mid-frame rewrite stays in shadow; a write on the first beat is committed with it
    clear_rules();
    cfg(0, 5, 8'h11, 8'hFF, 1'b1);
    out_q.delete();
    send_beat(mk_beat(8'h00, '1, 1'b0), 1'b0, '0, 1'b0);
    send_beat(mk_beat(8'h00, '1, 1'b0), 1'b1, mk_cfg(0, 5, 8'h22, 8'hFF, 1'b1), 1'b0);
    send_beat(mk_beat(8'h00, '1, 1'b1), 1'b0, '0, 1'b0);
    send_beat(mk_beat(8'h00, '1, 1'b1), 1'b0, '0, 1'b0);
    send_beat(mk_beat(8'h00, '1, 1'b1), 1'b1, mk_cfg(0, 5, 8'h33, 8'hFF, 1'b1), 1'b0);
    drain();
    chk("t3_current_frame", ob(0, 5), 8'h11);
    chk("t3_next_frame", ob(3, 5), 8'h22);
    chk("t3_coincident", ob(4, 5), 8'h33);

    // Priority between rules on the same offset; tkeep=0 lane forced to zero
    clear_rules();
    cfg(0, 5, 8'h01, 8'hFF, 1'b1);
    cfg(3, 5, 8'h03, 8'hFF, 1'b1);
    out_q.delete();
    send_beat(mk_beat(8'h40, '1, 1'b1), 1'b0, '0, 1'b0);
    kp = '1;
    kp[5] = 1'b0;
    send_beat(mk_beat(8'h40, kp, 1'b1), 1'b0, '0, 1'b0);
    drain();
    chk("t4_priority", ob(0, 5), 8'h03);
    chk("t4_unpatched", ob(0, 4), 8'h40);
    chk("t4_keep0", ob(1, 5), 8'h00);

    // Long frame: the beat offset must saturate, not wrap back onto offset 0
    clear_rules();
    cfg(0, 0, 8'hEE, 8'hFF, 1'b1);
    out_q.delete();
    for (int i = 0; i < 70; i++) send_beat(mk_beat(8'h00, '1, i == 69), 1'b0, '0, 1'b0);
    drain();
    chk("t5_first", ob(0, 0), 8'hEE);
    chk("t5_beat1", ob(1, 0), 8'h00);
    chk("t5_beat64", ob(64, 0), 8'h00);

    // Randomized traffic with 30% downstream ready and config churn
    in_total = 0;
    out_total = 0;
    for (int r = 0; r < 4; r++) cfg(r, $urandom_range(0, 260), 8'($urandom), 8'($urandom), 1'b1);
    for (int f = 0; f < 100; f++) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        b.d = rand_data();
        b.k = (i == nb - 1) ? {$urandom, $urandom} : '1;
        b.l = (i == nb - 1);
        b.u = 1'($urandom);
        if ($urandom_range(0, 3) == 0)
          send_beat(b, 1'b1, mk_cfg($urandom_range(0, 3), $urandom_range(0, 260), 8'($urandom),
                                    8'($urandom), $urandom_range(0, 3) != 0), 1'b1);
        else
          send_beat(b, 1'b0, '0, 1'b1);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        step(1'b0, '0, $urandom_range(0, 3) == 0,
             mk_cfg($urandom_range(0, 3), $urandom_range(0, 260), 8'($urandom), 8'($urandom), 1'b1),
             $urandom_range(0, 9) < 3, acc);
      end
    end
    drain();
    chk("rand_beat_count", out_total, in_total);

    // Reset on beat 2 of a 4-beat frame
    clear_rules();
    cfg(1, 2, 8'h77, 8'hFF, 1'b1);
    send_beat(mk_beat(8'h10, '1, 1'b0), 1'b0, '0, 1'b0);
    send_beat(mk_beat(8'h10, '1, 1'b0), 1'b0, '0, 1'b0);
    s_axis_tvalid = 1'b1;
    rst = 1'b1;
    m_axis_tready = 1'b1;
    cfg_wr_en = 1'b0;
    #1;
    if (m_axis_tvalid) begin
      b = exp_q.pop_front();
      chk("rst_inflight_dat", m_axis_tdata, b.d);
    end
    @(negedge clk);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    model_reset();
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_frame_active", frame_active, 1'b0);
    @(negedge clk);
    out_q.delete();
    send_beat(mk_beat(8'h10, '1, 1'b0), 1'b0, '0, 1'b0);
    send_beat(mk_beat(8'h10, '1, 1'b1), 1'b0, '0, 1'b0);
    drain();
    chk("midrst_rules_cleared", ob(0, 2), 8'h10);

`ifdef KUGELBLITZ_PATCH_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("stat_frames_rst", stat_frames, 32'd0);
    chk("stat_pframes_rst", stat_patched_frames, 32'd0);
    chk("stat_pbytes_rst", stat_patched_bytes, 32'd0);
    cfg(0, 3, 8'h5A, 8'hFF, 1'b1);
    cfg(1, 10, 8'hA5, 8'hFF, 1'b1);
    kp = '1;
    kp[3] = 1'b0;
    kp[10] = 1'b0;
    for (int f = 0; f < 10; f++) begin
      send_beat(mk_beat(8'h00, (f == 1 || f == 4 || f == 6 || f == 9) ? '1 : kp, 1'b1), 1'b0, '0, 1'b0);
    end
    drain();
    chk("stat_frames", stat_frames, 32'd10);
    chk("stat_patched_frames", stat_patched_frames, 32'd4);
    chk("stat_patched_bytes", stat_patched_bytes, 32'd8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
